// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single-port, synchronous-read data memory between the CPU
// memory-access stage and a loader/DMA requester.
//
// The CPU normally has priority. An aging counter forces a DMA grant after
// MAX_DMA_WAIT consecutive lost cycles, so the DMA always makes progress.
// Read data comes back one cycle after the access and is steered to the
// requester that issued the read.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req_valid/we/addr/wdata   CPU access (we == 0 means read)
//   cpu_flush                     squash this cycle's CPU access
//   cpu_stall                     CPU access not accepted this cycle
//   cpu_rsp_valid/rdata           CPU read response (one cycle after grant)
//   dma_req_valid/we/addr/wdata   DMA request, held stable until ready
//   dma_req_ready                 DMA request granted this cycle
//   dma_rsp_valid/rdata           DMA read response (one cycle after grant)
//   mem_we/addr/wdata             DMem access of the granted requester
//   mem_rdata                     DMem registered read data
module dmem_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int MAX_DMA_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req_valid,
    input  logic [DATA_W/8-1:0] cpu_req_we,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [DATA_W-1:0]   cpu_req_wdata,
    input  logic                cpu_flush,
    output logic                cpu_stall,
    output logic                cpu_rsp_valid,
    output logic [DATA_W-1:0]   cpu_rsp_rdata,
    input  logic                dma_req_valid,
    output logic                dma_req_ready,
    input  logic [DATA_W/8-1:0] dma_req_we,
    input  logic [ADDR_W-1:0]   dma_req_addr,
    input  logic [DATA_W-1:0]   dma_req_wdata,
    output logic                dma_rsp_valid,
    output logic [DATA_W-1:0]   dma_rsp_rdata,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(MAX_DMA_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_DMA_WAIT);

    typedef enum logic {
        CPU_PRIO,
        DMA_FORCE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_next;
    owner_t           rsp_owner, owner_next;

    logic cpu_act;
    logic cpu_grant;
    logic dma_grant;

    assign cpu_act = cpu_req_valid & ~cpu_flush;

    // State register: FSM state, DMA aging counter and read-response owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CPU_PRIO;
            wait_cnt  <= '0;
            rsp_owner <= OWN_NONE;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_next;
            rsp_owner <= owner_next;
        end
    end

    // Next-state logic. The aging counter counts consecutive cycles a pending
    // DMA request loses; reaching the limit forces a DMA grant next cycle.
    // Any DMA grant (or a withdrawn request) clears it, which also drops the
    // FSM back to CPU priority.
    always_comb begin
        wait_next = wait_cnt;
        if (dma_grant || !dma_req_valid) begin
            wait_next = '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_next = wait_cnt + 1'b1;
        end

        state_next = (wait_next == WAIT_MAX) ? DMA_FORCE : CPU_PRIO;

        // Only reads produce a response; writes leave the owner empty.
        owner_next = OWN_NONE;
        if (cpu_grant && (cpu_req_we == '0)) begin
            owner_next = OWN_CPU;
        end else if (dma_grant && (dma_req_we == '0)) begin
            owner_next = OWN_DMA;
        end
    end

    // Output logic: grants, stall, memory mux and response steering.
    // The response is masked while rst is high so that a read in flight
    // across reset never shows up.
    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        cpu_stall = 1'b0;
        unique case (state)
            CPU_PRIO: begin
                cpu_grant = cpu_act;
                dma_grant = ~cpu_act & dma_req_valid;
            end
            DMA_FORCE: begin
                dma_grant = dma_req_valid;
                cpu_stall = cpu_act;
            end
            default: ;
        endcase

        dma_req_ready = dma_grant;

        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_grant) begin
            mem_we    = cpu_req_we;
            mem_addr  = cpu_req_addr;
            mem_wdata = cpu_req_wdata;
        end else if (dma_grant) begin
            mem_we    = dma_req_we;
            mem_addr  = dma_req_addr;
            mem_wdata = dma_req_wdata;
        end

        cpu_rsp_valid = (rsp_owner == OWN_CPU) && !rst;
        dma_rsp_valid = (rsp_owner == OWN_DMA) && !rst;
        cpu_rsp_rdata = cpu_rsp_valid ? mem_rdata : '0;
        dma_rsp_rdata = dma_rsp_valid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Testbench for dmem_port_arbiter. Contains a behavioural DMem (registered
// read, byte writes) that is driven by the DUT memory port. It also holds a
// separate shadow copy of memory that the reference model updates
// from its own idea of which requester won each cycle.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int MAXW   = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                cpu_req_valid;
    logic [3:0]          cpu_req_we;
    logic [ADDR_W-1:0]   cpu_req_addr;
    logic [DATA_W-1:0]   cpu_req_wdata;
    logic                cpu_flush;
    logic                cpu_stall;
    logic                cpu_rsp_valid;
    logic [DATA_W-1:0]   cpu_rsp_rdata;
    logic                dma_req_valid;
    logic                dma_req_ready;
    logic [3:0]          dma_req_we;
    logic [ADDR_W-1:0]   dma_req_addr;
    logic [DATA_W-1:0]   dma_req_wdata;
    logic                dma_rsp_valid;
    logic [DATA_W-1:0]   dma_rsp_rdata;
    logic [3:0]          mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata = '0;

    logic [DATA_W-1:0]   dmem    [DEPTH];
    logic [DATA_W-1:0]   ref_mem [DEPTH];
    logic [DATA_W-1:0]   rd_word;

    int total = 0;
    int bad   = 0;

    dmem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_DMA_WAIT(MAXW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_we   (cpu_req_we),
        .cpu_req_addr (cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata),
        .cpu_flush    (cpu_flush),
        .cpu_stall    (cpu_stall),
        .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_rdata(cpu_rsp_rdata),
        .dma_req_valid(dma_req_valid),
        .dma_req_ready(dma_req_ready),
        .dma_req_we   (dma_req_we),
        .dma_req_addr (dma_req_addr),
        .dma_req_wdata(dma_req_wdata),
        .dma_rsp_valid(dma_rsp_valid),
        .dma_rsp_rdata(dma_rsp_rdata),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int a);
        if (a == 'h10) return 32'hDEADBEEF;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural DMem: read returns the pre-write contents one cycle later.
    initial begin
        for (int i = 0; i < DEPTH; i++) dmem[i] = init_word(i);
        forever begin
            @(posedge clk);
            rd_word = dmem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) dmem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
            mem_rdata <= rd_word;
        end
    end

    task automatic write_ref(input logic [ADDR_W-1:0] a, input logic [3:0] we,
                             input logic [31:0] wd);
        for (int b = 0; b < 4; b++)
            if (we[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic set_cpu(input logic v, input logic [3:0] we,
                           input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                           input logic fl);
        cpu_req_valid = v;
        cpu_req_we    = we;
        cpu_req_addr  = a;
        cpu_req_wdata = wd;
        cpu_flush     = fl;
    endtask

    task automatic set_dma(input logic v, input logic [3:0] we,
                           input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        dma_req_valid = v;
        dma_req_we    = we;
        dma_req_addr  = a;
        dma_req_wdata = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs while reset is held with idle requesters.
    task automatic test_reset();
        rst = 1'b1;
        set_cpu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        step();
        step();
        @(negedge clk);
        total++; if (cpu_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_cpu_rsp: got %b expected 0", cpu_rsp_valid); end
        total++; if (dma_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_dma_rsp: got %b expected 0", dma_rsp_valid); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b expected 0", cpu_stall); end
        total++; if (mem_we !== 4'h0 || mem_addr !== '0 || mem_wdata !== '0) begin bad++; $display("[TB] FAIL reset_mem_idle: got we=%h addr=%h wd=%h expected zeros", mem_we, mem_addr, mem_wdata); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_cpu_read();
        set_cpu(1, 4'h0, 14'h10, 0, 0);
        @(negedge clk);
        total++; if (mem_addr !== 14'h10 || mem_we !== 4'h0) begin bad++; $display("[TB] FAIL cpu_read_mem: got addr=%h we=%h expected 10/0", mem_addr, mem_we); end
        total++; if (cpu_stall !== 1'b0 || dma_req_ready !== 1'b0) begin bad++; $display("[TB] FAIL cpu_read_grant: got stall=%b ready=%b expected 0/0", cpu_stall, dma_req_ready); end
        step();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL cpu_read_rsp: got v=%b d=%h expected 1/deadbeef", cpu_rsp_valid, cpu_rsp_rdata); end
        total++; if (dma_rsp_valid !== 1'b0 || dma_rsp_rdata !== '0) begin bad++; $display("[TB] FAIL cpu_read_dma_quiet: got v=%b d=%h expected 0/0", dma_rsp_valid, dma_rsp_rdata); end
        step();
    endtask

    // CPU reads every cycle while DMA waits: forced grant on the 9th cycle.
    task automatic test_aging();
        logic [ADDR_W-1:0] caddr, prev_addr;
        logic prev_dma;
        prev_addr = '0;
        prev_dma  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            caddr = (k == 9) ? 14'h108 : 14'(14'h100 + k);
            set_cpu(1, 4'h0, caddr, 0, 0);
            set_dma(k <= 8, 4'h0, 14'h30, 0);
            @(negedge clk);
            total++; if (cpu_stall !== (k == 8)) begin bad++; $display("[TB] FAIL aging_stall k=%0d: got %b expected %b", k, cpu_stall, k == 8); end
            total++; if (dma_req_ready !== (k == 8)) begin bad++; $display("[TB] FAIL aging_ready k=%0d: got %b expected %b", k, dma_req_ready, k == 8); end
            total++; if (mem_addr !== ((k == 8) ? 14'h30 : caddr)) begin bad++; $display("[TB] FAIL aging_addr k=%0d: got %h", k, mem_addr); end
            if (k > 0) begin
                if (prev_dma) begin
                    total++; if (dma_rsp_valid !== 1'b1 || dma_rsp_rdata !== ref_mem[14'h30]) begin bad++; $display("[TB] FAIL aging_dma_rsp: got v=%b d=%h expected 1/%h", dma_rsp_valid, dma_rsp_rdata, ref_mem[14'h30]); end
                end else begin
                    total++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== ref_mem[prev_addr]) begin bad++; $display("[TB] FAIL aging_cpu_rsp k=%0d: got v=%b d=%h expected 1/%h", k, cpu_rsp_valid, cpu_rsp_rdata, ref_mem[prev_addr]); end
                end
            end
            prev_dma  = (k == 8);
            prev_addr = caddr;
            step();
        end
        set_cpu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        @(negedge clk);
        total++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== ref_mem[14'h108]) begin bad++; $display("[TB] FAIL aging_last_rsp: got v=%b d=%h expected 1/%h", cpu_rsp_valid, cpu_rsp_rdata, ref_mem[14'h108]); end
        step();
    endtask

    task automatic test_dma_write();
        set_dma(1, 4'b0011, 14'h20, 32'h0000ABCD);
        @(negedge clk);
        total++; if (dma_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL dma_write_ready: got %b expected 1", dma_req_ready); end
        total++; if (mem_we !== 4'b0011 || mem_addr !== 14'h20 || mem_wdata !== 32'h0000ABCD) begin bad++; $display("[TB] FAIL dma_write_mem: got we=%b addr=%h wd=%h", mem_we, mem_addr, mem_wdata); end
        write_ref(14'h20, 4'b0011, 32'h0000ABCD);
        step();
        set_dma(0, 0, 0, 0);
        set_cpu(1, 4'h0, 14'h20, 0, 0);
        @(negedge clk);
        total++; if (dma_rsp_valid !== 1'b0 || cpu_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL dma_write_no_rsp: got dma=%b cpu=%b expected 0/0", dma_rsp_valid, cpu_rsp_valid); end
        step();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata[15:0] !== 16'hABCD || cpu_rsp_rdata !== ref_mem[14'h20]) begin bad++; $display("[TB] FAIL dma_write_readback: got v=%b d=%h expected 1/%h", cpu_rsp_valid, cpu_rsp_rdata, ref_mem[14'h20]); end
        step();
    endtask

    task automatic test_flush();
        set_cpu(1, 4'hF, 14'h70, 32'hFFFFFFFF, 1);
        @(negedge clk);
        total++; if (mem_we !== 4'h0 || mem_addr !== '0 || cpu_stall !== 1'b0 || dma_req_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_alone: got we=%h addr=%h stall=%b ready=%b", mem_we, mem_addr, cpu_stall, dma_req_ready); end
        step();
        set_dma(1, 4'h0, 14'h40, 0);
        @(negedge clk);
        total++; if (dma_req_ready !== 1'b1 || mem_addr !== 14'h40 || mem_we !== 4'h0 || cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL flush_dma: got ready=%b addr=%h we=%h stall=%b", dma_req_ready, mem_addr, mem_we, cpu_stall); end
        step();
        set_cpu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        @(negedge clk);
        total++; if (dma_rsp_valid !== 1'b1 || dma_rsp_rdata !== ref_mem[14'h40] || cpu_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_dma_rsp: got dv=%b d=%h cv=%b expected 1/%h/0", dma_rsp_valid, dma_rsp_rdata, cpu_rsp_valid, ref_mem[14'h40]); end
        step();
    endtask

    task automatic test_back_to_back();
        set_cpu(1, 4'h0, 14'h50, 0, 0);
        step();
        set_cpu(0, 0, 0, 0, 0);
        set_dma(1, 4'h0, 14'h60, 0);
        @(negedge clk);
        total++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== ref_mem[14'h50] || dma_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_first: got cv=%b d=%h dv=%b", cpu_rsp_valid, cpu_rsp_rdata, dma_rsp_valid); end
        step();
        set_dma(0, 0, 0, 0);
        set_cpu(1, 4'h0, 14'h5C, 0, 0);
        @(negedge clk);
        total++; if (dma_rsp_valid !== 1'b1 || dma_rsp_rdata !== ref_mem[14'h60] || cpu_rsp_valid !== 1'b0 || cpu_rsp_rdata !== '0) begin bad++; $display("[TB] FAIL b2b_second: got dv=%b d=%h cv=%b cd=%h", dma_rsp_valid, dma_rsp_rdata, cpu_rsp_valid, cpu_rsp_rdata); end
        step();
        set_cpu(0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== ref_mem[14'h5C] || dma_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_third: got cv=%b d=%h dv=%b", cpu_rsp_valid, cpu_rsp_rdata, dma_rsp_valid); end
        step();
    endtask

    // Reset in the cycle after a CPU read drops the response and restarts
    // the DMA aging from zero even though DMA had already lost 6 cycles.
    task automatic test_reset_drop();
        for (int k = 0; k < 5; k++) begin
            set_cpu(1, 4'h0, 14'h10, 0, 0);
            set_dma(1, 4'h0, 14'h31, 0);
            step();
        end
        rst = 1'b1;
        @(negedge clk);
        total++; if (cpu_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_drop_rsp: got %b expected 0", cpu_rsp_valid); end
        total++; if (cpu_stall !== 1'b0 || mem_addr !== 14'h10 || dma_req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_grant: got stall=%b addr=%h ready=%b", cpu_stall, mem_addr, dma_req_ready); end
        step();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) begin
                total++; if (cpu_rsp_valid !== 1'b0 || dma_rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_after_rsp: got cv=%b dv=%b expected 0/0", cpu_rsp_valid, dma_rsp_valid); end
            end
            total++; if (dma_req_ready !== (k == 8)) begin bad++; $display("[TB] FAIL rst_aging k=%0d: got %b expected %b", k, dma_req_ready, k == 8); end
            step();
        end
        set_cpu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        step();
        step();
    endtask

    // Random traffic against a reference model. The model tracks how many
    // consecutive cycles the current DMA request has lost. After MAXW
    // losses, DMA takes the port. Otherwise an active CPU wins.
    task automatic test_random();
        int losses = 0;
        int exp_owner = 0;
        logic [31:0] exp_data = '0;
        logic stalled = 1'b0;
        logic dv = 1'b0;
        logic [3:0] dwe = '0, cwe = '0;
        logic [ADDR_W-1:0] daddr = '0, caddr = '0;
        logic [31:0] dwd = '0, cwd = '0;
        logic cv = 1'b0, cfl = 1'b0;
        logic act, cpu_g, dma_g, e_stall;
        logic [3:0] e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [31:0] e_wd;
        for (int t = 0; t <= 400; t++) begin
            if (t == 400) begin
                cv = 1'b0; cfl = 1'b0; dv = 1'b0;
            end else begin
                if (!stalled) begin
                    cv    = ($urandom_range(3) != 0);
                    cwe   = ($urandom_range(2) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
                    caddr = 14'($urandom_range(15));
                    cwd   = $urandom;
                    cfl   = ($urandom_range(7) == 0);
                end
                if (!dv) begin
                    if ($urandom_range(1) == 1) begin
                        dv    = 1'b1;
                        dwe   = ($urandom_range(2) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
                        daddr = 14'($urandom_range(15));
                        dwd   = $urandom;
                    end
                end else if (losses < MAXW && $urandom_range(15) == 0) begin
                    dv = 1'b0;
                end
            end
            set_cpu(cv, cwe, caddr, cwd, cfl);
            set_dma(dv, dwe, daddr, dwd);

            act = cv && !cfl;
            if (dv && losses >= MAXW) begin
                dma_g = 1'b1; cpu_g = 1'b0; e_stall = act;
            end else begin
                cpu_g = act; dma_g = !act && dv; e_stall = 1'b0;
            end
            e_we   = cpu_g ? cwe   : dma_g ? dwe   : 4'h0;
            e_addr = cpu_g ? caddr : dma_g ? daddr : '0;
            e_wd   = cpu_g ? cwd   : dma_g ? dwd   : '0;

            @(negedge clk);
            total++; if (cpu_stall !== e_stall || dma_req_ready !== dma_g) begin bad++; $display("[TB] FAIL rand_grant t=%0d: got stall=%b ready=%b expected %b/%b", t, cpu_stall, dma_req_ready, e_stall, dma_g); end
            total++; if (mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wd) begin bad++; $display("[TB] FAIL rand_mem t=%0d: got %h/%h/%h expected %h/%h/%h", t, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wd); end
            total++; if (cpu_rsp_valid !== (exp_owner == 1) || cpu_rsp_rdata !== ((exp_owner == 1) ? exp_data : 32'h0)) begin bad++; $display("[TB] FAIL rand_cpu_rsp t=%0d: got %b/%h expected %b/%h", t, cpu_rsp_valid, cpu_rsp_rdata, exp_owner == 1, exp_data); end
            total++; if (dma_rsp_valid !== (exp_owner == 2) || dma_rsp_rdata !== ((exp_owner == 2) ? exp_data : 32'h0)) begin bad++; $display("[TB] FAIL rand_dma_rsp t=%0d: got %b/%h expected %b/%h", t, dma_rsp_valid, dma_rsp_rdata, exp_owner == 2, exp_data); end

            exp_owner = 0;
            if (cpu_g || dma_g) begin
                if (e_we != 4'h0) begin
                    write_ref(e_addr, e_we, e_wd);
                end else begin
                    exp_owner = cpu_g ? 1 : 2;
                    exp_data  = ref_mem[e_addr];
                end
            end
            if (dma_g || !dv) losses = 0;
            else if (losses < MAXW) losses++;
            stalled = e_stall;
            if (dma_g) dv = 1'b0;
            step();
        end
        set_cpu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        step();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_cpu_read();
        test_aging();
        test_dma_write();
        test_flush();
        test_back_to_back();
        test_reset_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
